// File: rtl/alu_mul_seq.sv
// Shift-and-add MUL/MLA sequencer that borrows the shared ALU for one add per cycle.
// Latency: done pulses in the cycle after edge N+1, where N = (index of highest set bit of Rs) + 1.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, not queued.
module alu_mul_seq #(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] ALU_ADD_OP = 4'b0100
) (
  input  logic             in_Clock,
  input  logic             in_Reset,
  input  logic             in_Start,
  input  logic             in_Accumulate,
  input  logic [WIDTH-1:0] in_Rm,
  input  logic [WIDTH-1:0] in_Rs,
  input  logic [WIDTH-1:0] in_Rn,
  output logic [WIDTH-1:0] out_ALU_Rn,
  output logic [WIDTH-1:0] out_ALU_Op2,
  output logic             out_ALU_Carry,
  output logic [3:0]       out_ALU_Opcode,
  input  logic [WIDTH-1:0] in_ALU_Y,
  output logic             out_Busy,
  output logic             out_Done,
  output logic [WIDTH-1:0] out_Result,
  output logic [1:0]       out_NZ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       nz_q;

  // State and datapath registers; operands are captured once so later input changes are harmless.
  always_ff @(posedge in_Clock or posedge in_Reset) begin
    if (in_Reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
    end
  end

  // Next-state and datapath update: one partial-product add per LOOP cycle, exit once multiplier is spent.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    case (state)
      S_IDLE: begin
        if (in_Start) begin
          acc_nxt    = in_Accumulate ? in_Rn : '0;
          mcand_nxt  = in_Rm;
          mplier_nxt = in_Rs;
          state_nxt  = (in_Rs != '0) ? S_LOOP : S_DONE;
        end
      end
      S_LOOP: begin
        acc_nxt    = in_ALU_Y;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        if (mplier_nxt == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Result/flags are loaded on the edge entering DONE so they are already valid during the Done pulse,
  // then held until the next completion.
  always_ff @(posedge in_Clock or posedge in_Reset) begin
    if (in_Reset) begin
      result_q <= '0;
      nz_q     <= 2'b01;
    end else if (state_nxt == S_DONE) begin
      result_q <= acc_nxt;
      nz_q     <= {acc_nxt[WIDTH-1], (acc_nxt == '0)};
    end
  end

  // ALU is always asked to ADD accumulator + (multiplier LSB ? multiplicand : 0); harmless outside LOOP.
  always_comb begin
    out_ALU_Rn     = acc;
    out_ALU_Op2    = mplier[0] ? mcand : '0;
    out_ALU_Carry  = 1'b0;
    out_ALU_Opcode = ALU_ADD_OP;
    out_Busy       = (state != S_IDLE);
    out_Done       = (state == S_DONE);
    out_Result     = result_q;
    out_NZ         = nz_q;
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: table of MUL/MLA vectors plus hand-written corner sequences.
// A behavioural ADD-only ALU closes the loop around the sequencer.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the falling edge or after sampling.
module tb_alu_mul_seq;

  logic        in_Clock = 1'b0;
  logic        in_Reset = 1'b1;
  logic        in_Start = 1'b0;
  logic        in_Accumulate = 1'b0;
  logic [31:0] in_Rm = '0;
  logic [31:0] in_Rs = '0;
  logic [31:0] in_Rn = '0;
  logic [31:0] out_ALU_Rn;
  logic [31:0] out_ALU_Op2;
  logic        out_ALU_Carry;
  logic [3:0]  out_ALU_Opcode;
  logic [31:0] in_ALU_Y;
  logic        out_Busy;
  logic        out_Done;
  logic [31:0] out_Result;
  logic [1:0]  out_NZ;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mul_seq #(.WIDTH(32), .ALU_ADD_OP(4'b0100)) dut (
    .in_Clock      (in_Clock),
    .in_Reset      (in_Reset),
    .in_Start      (in_Start),
    .in_Accumulate (in_Accumulate),
    .in_Rm         (in_Rm),
    .in_Rs         (in_Rs),
    .in_Rn         (in_Rn),
    .out_ALU_Rn    (out_ALU_Rn),
    .out_ALU_Op2   (out_ALU_Op2),
    .out_ALU_Carry (out_ALU_Carry),
    .out_ALU_Opcode(out_ALU_Opcode),
    .in_ALU_Y      (in_ALU_Y),
    .out_Busy      (out_Busy),
    .out_Done      (out_Done),
    .out_Result    (out_Result),
    .out_NZ        (out_NZ)
  );

  // Behavioural ALU: the sequencer only ever asks for ADD.
  assign in_ALU_Y = out_ALU_Rn + out_ALU_Op2 + {31'd0, out_ALU_Carry};

  always #5 in_Clock = ~in_Clock;

  typedef struct {
    string       name;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] rn;
    logic        acc;
    logic [31:0] res;
    logic [1:0]  nz;
    int          edges;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and follow it to its Done pulse, checking latency, busy span and result.
  task automatic run_op(input string name, input logic [31:0] rm, input logic [31:0] rs,
                        input logic [31:0] rn, input logic acc, input logic [31:0] exp_res,
                        input logic [1:0] exp_nz, input int exp_edges);
    int edges;
    int busy_cnt;
    @(negedge in_Clock);
    in_Rm = rm; in_Rs = rs; in_Rn = rn; in_Accumulate = acc; in_Start = 1'b1;
    @(posedge in_Clock);
    #1;
    in_Start = 1'b0;
    // Scramble operands after the start edge; they must not matter.
    in_Rm = 32'hDEADBEEF; in_Rs = 32'h12345678; in_Rn = 32'hCAFEF00D;
    edges = 1;
    busy_cnt = out_Busy ? 1 : 0;
    while (!out_Done && edges < 200) begin
      @(posedge in_Clock);
      #1;
      edges++;
      if (out_Busy) busy_cnt++;
    end
    check({name, " done"},    {31'd0, out_Done}, 32'd1);
    check({name, " latency"}, edges,             exp_edges);
    check({name, " busy"},    busy_cnt,          exp_edges);
    check({name, " result"},  out_Result,        exp_res);
    check({name, " nz"},      {30'd0, out_NZ},   {30'd0, exp_nz});
    @(posedge in_Clock);
    #1;
    check({name, " idle"},    {31'd0, out_Busy}, 32'd0);
    check({name, " hold"},    out_Result,        exp_res);
  endtask

  initial begin
    logic [31:0] exp_op2 [3];
    logic [31:0] exp_rn  [3];
    int edges;

    vecs[0] = '{"mul3x5",   32'd3,        32'd5,        32'd0,   1'b0, 32'd15,         2'b00, 4};
    vecs[1] = '{"mla0_42",  32'd9,        32'd0,        32'd42,  1'b1, 32'd42,         2'b00, 1};
    vecs[2] = '{"mla0_0",   32'd9,        32'd0,        32'd0,   1'b1, 32'd0,          2'b01, 1};
    vecs[3] = '{"wrapneg",  32'hFFFFFFFF, 32'h80000000, 32'd0,   1'b0, 32'h80000000,   2'b10, 33};
    vecs[4] = '{"wrapzero", 32'h00010000, 32'h00010000, 32'd0,   1'b0, 32'd0,          2'b01, 18};
    vecs[5] = '{"mla6x7",   32'd6,        32'd7,        32'd100, 1'b1, 32'd142,        2'b00, 4};
    vecs[6] = '{"mlaneg",   32'hFFFFFFFD, 32'd4,        32'd1,   1'b1, 32'hFFFFFFF5,   2'b10, 4};

    // Reset state.
    #12;
    check("rst busy",   {31'd0, out_Busy}, 32'd0);
    check("rst done",   {31'd0, out_Done}, 32'd0);
    check("rst result", out_Result,        32'd0);
    check("rst nz",     {30'd0, out_NZ},   32'd1);
    @(negedge in_Clock);
    in_Reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].name, vecs[i].rm, vecs[i].rs, vecs[i].rn, vecs[i].acc,
             vecs[i].res, vecs[i].nz, vecs[i].edges);
    end

    // ALU interface sequence during 3*5.
    exp_op2[0] = 32'd3; exp_op2[1] = 32'd0; exp_op2[2] = 32'd12;
    exp_rn[0]  = 32'd0; exp_rn[1]  = 32'd3; exp_rn[2]  = 32'd3;
    @(negedge in_Clock);
    in_Rm = 32'd3; in_Rs = 32'd5; in_Rn = 32'd0; in_Accumulate = 1'b0; in_Start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge in_Clock);
      #1;
      in_Start = 1'b0;
      check("alu opcode", {28'd0, out_ALU_Opcode}, 32'h4);
      check("alu carry",  {31'd0, out_ALU_Carry},  32'd0);
      check("alu op2",    out_ALU_Op2,             exp_op2[k]);
      check("alu rn",     out_ALU_Rn,              exp_rn[k]);
    end
    @(posedge in_Clock);
    #1;
    check("alu seq done",   {31'd0, out_Done}, 32'd1);
    check("alu seq result", out_Result,        32'd15);
    @(posedge in_Clock);
    #1;

    // Start held high while busy: 6*7 then a second op 1*1 only after returning to IDLE.
    @(negedge in_Clock);
    in_Rm = 32'd6; in_Rs = 32'd7; in_Accumulate = 1'b0; in_Start = 1'b1;
    @(posedge in_Clock);
    #1;
    in_Rm = 32'd1; in_Rs = 32'd1;
    edges = 1;
    while (!out_Done && edges < 100) begin
      @(posedge in_Clock);
      #1;
      edges++;
    end
    check("hold first latency", edges,      4);
    check("hold first result",  out_Result, 32'd42);
    @(posedge in_Clock);
    #1;
    check("hold idle gap", {31'd0, out_Busy}, 32'd0);
    @(posedge in_Clock);
    #1;
    in_Start = 1'b0;
    check("hold restart busy", {31'd0, out_Busy}, 32'd1);
    @(posedge in_Clock);
    #1;
    check("hold second done",   {31'd0, out_Done}, 32'd1);
    check("hold second result", out_Result,        32'd1);
    @(posedge in_Clock);
    #1;

    // Asynchronous reset in the middle of a long multiply.
    @(negedge in_Clock);
    in_Rm = 32'd7; in_Rs = 32'd255; in_Accumulate = 1'b0; in_Start = 1'b1;
    @(posedge in_Clock);
    #1;
    in_Start = 1'b0;
    repeat (3) @(posedge in_Clock);
    #2;
    check("midrst busy before", {31'd0, out_Busy}, 32'd1);
    in_Reset = 1'b1;
    #1;
    check("midrst busy",   {31'd0, out_Busy}, 32'd0);
    check("midrst done",   {31'd0, out_Done}, 32'd0);
    check("midrst result", out_Result,        32'd0);
    check("midrst nz",     {30'd0, out_NZ},   32'd1);
    @(negedge in_Clock);
    in_Reset = 1'b0;
    run_op("postrst2x2", 32'd2, 32'd2, 32'd0, 1'b0, 32'd4, 2'b00, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle sequencer that executes MUL (Rd = Rm*Rs) and MLA (Rd = Rm*Rs + Rn) on the shared ALU using shift-and-add, one ALU add per cycle. It sits beside the alu in the execute stage. While busy it owns the ALU operand and opcode inputs through an upstream mux selected by out_Busy. It ends each multiply early once the remaining multiplier bits are zero.

Parameters:
WIDTH, `WordWidth (32), operand/result width
ALU_ADD_OP, 4'b0100, ALU opcode value for ADD (`ALUType_Add)

Ports:
in_Clock  input  1  rising-edge clock
in_Reset  input  1  asynchronous, active-high reset
in_Start  input  1  start request, sampled only in IDLE
in_Accumulate  input  1  1 = MLA, 0 = MUL; sampled with in_Start
in_Rm  input  WIDTH  multiplicand
in_Rs  input  WIDTH  multiplier
in_Rn  input  WIDTH  accumulate addend (MLA only)
out_ALU_Rn  output  WIDTH  ALU operand A = accumulator register
out_ALU_Op2  output  WIDTH  ALU operand B = multiplicand register if multiplier LSB = 1, else 0
out_ALU_Carry  output  1  constant 0
out_ALU_Opcode  output  4  constant ALU_ADD_OP
in_ALU_Y  input  WIDTH  ALU result
out_Busy  output  1  sequencer owns the ALU (LOOP or DONE)
out_Done  output  1  one-cycle completion pulse
out_Result  output  WIDTH  product (low WIDTH bits)
out_NZ  output  2  {N, Z} of out_Result; C/V are not produced (CPSR C/V left unchanged by the consumer)

Behaviour:
- Internal registers: Acc, Mcand, Mplier (WIDTH each). State is one of IDLE, LOOP, DONE.
- Reset (asynchronous, any state):
  - state = IDLE; Acc, Mcand, Mplier = 0.
  - out_Busy = 0, out_Done = 0, out_Result = 0, out_NZ = 2'b01.
- IDLE:
  - out_Busy = 0. On an edge with in_Start = 1, load Acc = in_Accumulate ? in_Rn : 0, Mcand = in_Rm, Mplier = in_Rs.
  - Next state is LOOP if in_Rs != 0, else DONE.
  - in_Start = 0 leaves state and registers unchanged.
- LOOP:
  - out_Busy = 1. The ALU is driven combinationally from the registers.
  - Each edge updates Acc = in_ALU_Y, Mcand = Mcand << 1, Mplier = Mplier >> 1 (logical).
  - Transition to DONE when (Mplier >> 1) == 0; otherwise stay in LOOP.
- DONE:
  - out_Busy = 1 and out_Done = 1 for exactly one cycle. out_Result = Acc and out_NZ = {Acc[WIDTH-1], Acc == 0} are registered and update in this cycle.
  - Next state is IDLE.
- Hold: out_Result and out_NZ hold their value until the next DONE or reset.
- Latency: with N = index of highest set bit of in_Rs, plus 1 (N = 0 when in_Rs = 0), out_Done is high in the cycle after edge N+1, counting the start-sampling edge as edge 1. Maximum N = WIDTH.
- Arithmetic: all sums wrap modulo 2^WIDTH. Signed and unsigned operands yield identical low bits; no sign handling.
- in_Start while busy: ignored; no queuing.
- A new start is accepted only in IDLE, i.e. at the earliest one cycle after the out_Done pulse.
- Operand inputs are don't-care after the start edge; changes have no effect on the result.
- in_ALU_Y is consumed only in LOOP.
- ALU output lines: out_ALU_Rn and out_ALU_Op2 are don't-care outside LOOP but must be driven (no X). Driving registered values is acceptable.

Test Plan:
- Reset: assert in_Reset mid-LOOP (in_Rm = 7, in_Rs = 255, start, then reset after 3 clocks) -> immediately out_Busy = 0, out_Done = 0, out_Result = 0, out_NZ = 2'b01. A subsequent start with in_Rm = 2, in_Rs = 2 completes with out_Result = 4.
- MUL 3*5: in_Rm = 3, in_Rs = 5, in_Accumulate = 0, pulse start -> out_Busy high for 4 cycles, out_Done in the cycle after edge 4, out_Result = 15, out_NZ = 2'b00.
- MLA with zero multiplier: in_Rm = 9, in_Rs = 0, in_Rn = 42, in_Accumulate = 1 -> out_Done in the cycle after edge 1, out_Result = 42. Repeat with in_Rn = 0 -> out_Result = 0, out_NZ = 2'b01.
- Wrap/negative: in_Rm = 32'hFFFFFFFF, in_Rs = 32'h80000000, MUL -> 32 LOOP cycles, out_Result = 32'h80000000, out_NZ = 2'b10. Also in_Rm = 32'h10000, in_Rs = 32'h10000 -> out_Result = 0, Z = 1.
- Start while busy: in_Rm = 6, in_Rs = 7 (3 loops), hold in_Start = 1 throughout -> first result 42. A second operation starts on the IDLE edge after Done, and in_Start seen during LOOP is ignored.
- ALU interface: during the 3*5 run, check out_ALU_Opcode = 4'b0100 and out_ALU_Carry = 0. Check out_ALU_Op2 sequence = 3, 0, 12 and out_ALU_Rn sequence = 0, 3, 3.
